shreg_ctrl: RTL and testbench

Command sequencer for the universal shift register built from `mid_mux`/`left_mux` and `ff_d` cells. It accepts one command at a time through a valid/ready handshake. For each command it drives the register's `ENB`, `MODO1`, `MODO0`, `DIR`, `S_IN` and parallel `D` lines for the required number of clock cycles, then pulses `DONE`. It sits between the test/host logic and the register, and it is the only driver of the register's control lines.

---
 rtl/shreg_ctrl_pkg.sv | 36 +++
 rtl/shreg_cnt.sv | 28 ++
 rtl/shreg_ctrl.sv | 145 ++++++++++++++
 tb/tb_shreg_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_ctrl_pkg.sv
// Shared opcodes, FSM encoding and register mode constants for the shift-register sequencer.
// MODO_* values are what the register expects on MODO1 (load) and MODO0 (serial vs circular).
package shreg_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROTL = 3'd4,
        OP_ROTR = 3'd5,
        OP_WAIT = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic MODO_LOAD = 1'b1;
    localparam logic MODO_SER  = 1'b0;
    localparam logic MODO_CIRC = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Opcodes that occupy at least one RUN cycle (given a non-zero count).
    function automatic logic has_run(op_e op);
        case (op)
            OP_LOAD, OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_WAIT: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shreg_cnt.sv
// Loadable down-counter; last flags count==1 so the FSM leaves RUN after exactly N cycles.
// Decrement stops at zero, so a full-scale load never wraps.
module shreg_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shreg_ctrl.sv
// Command sequencer for the universal shift register: ENB high N cycles after accept, DONE one cycle later.
// One command in flight; CMD_READY only in IDLE, so a requester holds CMD_VALID until accepted.
module shreg_ctrl
    import shreg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_CNT,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic             SER_DATA,
    output logic             SER_REQ,
    output logic             ENB,
    output logic             MODO1,
    output logic             MODO0,
    output logic             DIR,
    output logic             S_IN,
    output logic [WIDTH-1:0] D,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    state_e           state, state_nxt;
    op_e              cmd_op, op_q, op_cur;
    logic             accept, zero_len, cnt_last;
    logic [CNT_W-1:0] cnt_init;

    logic             enb_nxt, m1_nxt, m0_nxt, dir_nxt, sin_nxt, req_nxt;
    logic             busy_nxt, done_nxt, err_nxt, ready_nxt;
    logic [WIDTH-1:0] d_nxt;

    assign cmd_op   = op_e'(CMD_OP);
    assign accept   = CMD_VALID && CMD_READY;
    assign op_cur   = accept ? cmd_op : op_q;
    assign cnt_init = (cmd_op == OP_LOAD) ? CNT_W'(1) : CMD_CNT;
    assign zero_len = !has_run(cmd_op) || (cnt_init == '0);

    shreg_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (CLK),
        .rst_n    (RESET_L),
        .load     (accept),
        .load_val (cnt_init),
        .dec      (state == ST_RUN),
        .last     (cnt_last)
    );

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= cmd_op;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = zero_len ? ST_FIN : ST_RUN;
            ST_RUN:  if (cnt_last) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Mode/data lines hold their value unless a RUN cycle needs them changed.
        enb_nxt   = 1'b0;
        req_nxt   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        m1_nxt    = MODO1;
        m0_nxt    = MODO0;
        dir_nxt   = DIR;
        sin_nxt   = S_IN;
        d_nxt     = D;
        busy_nxt  = (state_nxt != ST_IDLE);
        ready_nxt = (state_nxt == ST_IDLE);

        if (state_nxt == ST_RUN) begin
            case (op_cur)
                OP_LOAD: begin
                    // LOAD's single RUN cycle always starts at the accept edge.
                    enb_nxt = 1'b1;
                    m1_nxt  = MODO_LOAD;
                    d_nxt   = CMD_DATA;
                end
                OP_SHL, OP_SHR: begin
                    enb_nxt = 1'b1;
                    m1_nxt  = ~MODO_LOAD;
                    m0_nxt  = MODO_SER;
                    dir_nxt = (op_cur == OP_SHR) ? DIR_RIGHT : DIR_LEFT;
                    sin_nxt = SER_DATA;
                    req_nxt = 1'b1;
                end
                OP_ROTL, OP_ROTR: begin
                    enb_nxt = 1'b1;
                    m1_nxt  = ~MODO_LOAD;
                    m0_nxt  = MODO_CIRC;
                    dir_nxt = (op_cur == OP_ROTR) ? DIR_RIGHT : DIR_LEFT;
                end
                default: ;
            endcase
        end else if (state_nxt == ST_FIN) begin
            done_nxt = 1'b1;
            err_nxt  = (op_cur == OP_RSVD);
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            CMD_READY <= 1'b0;
            ENB       <= 1'b0;
            MODO1     <= 1'b0;
            MODO0     <= 1'b0;
            DIR       <= 1'b0;
            S_IN      <= 1'b0;
            SER_REQ   <= 1'b0;
            D         <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            CMD_READY <= ready_nxt;
            ENB       <= enb_nxt;
            MODO1     <= m1_nxt;
            MODO0     <= m0_nxt;
            DIR       <= dir_nxt;
            S_IN      <= sin_nxt;
            SER_REQ   <= req_nxt;
            D         <= d_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
            ERR       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_shreg_ctrl.sv
`timescale 1ns/1ps
// Directed bench for shreg_ctrl: an expected-output timeline per cycle built from the command rules,
// plus a 4-bit register stand-in driven by the controller outputs.
module tb_shreg_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int DEPTH = 256;

    localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_SHL = 3'd2, OP_SHR = 3'd3;
    localparam logic [2:0] OP_ROTL = 3'd4, OP_ROTR = 3'd5, OP_WAIT = 3'd6, OP_RSVD = 3'd7;

    logic             CLK = 1'b0;
    logic             RESET_L;
    logic             CMD_VALID, CMD_READY;
    logic [2:0]       CMD_OP;
    logic [CNT_W-1:0] CMD_CNT;
    logic [WIDTH-1:0] CMD_DATA;
    logic             SER_DATA, SER_REQ;
    logic             ENB, MODO1, MODO0, DIR, S_IN;
    logic [WIDTH-1:0] D;
    logic             BUSY, DONE, ERR;

    always #5 CLK = ~CLK;

    shreg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_CNT(CMD_CNT), .CMD_DATA(CMD_DATA), .SER_DATA(SER_DATA),
        .SER_REQ(SER_REQ), .ENB(ENB), .MODO1(MODO1), .MODO0(MODO0), .DIR(DIR),
        .S_IN(S_IN), .D(D), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    typedef struct packed {
        logic ready, busy, enb, done, err, m1, m0, dir, sin, req;
        logic [WIDTH-1:0] d;
    } exp_t;

    // exp_q[c] = outputs required in the cycle after clock edge c.
    exp_t exp_q [DEPTH];
    exp_t held, act;
    int   cyc = 0, checks = 0, failures = 0;
    int   enb_total = 0, req_total = 0, done_total = 0, done_cyc = -1;
    int   k, k1, k2, e0, r0, h0, d0;
    logic done_err = 1'b0;
    logic [3:0] reg_q = 4'b0000;
    logic [3:0] hist [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic lit(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic int hist_at(input int i);
        return (i < hist.size()) ? int'(hist[i]) : -1;
    endfunction

    task automatic put(input int idx, input logic rdy, input logic busy, input logic enb,
                       input logic done, input logic err, input logic req);
        exp_t e;
        if (idx < 0 || idx >= DEPTH) return;
        e = held;
        e.ready = rdy; e.busy = busy; e.enb = enb; e.done = done; e.err = err; e.req = req;
        exp_q[idx] = e;
    endtask

    // Accept at edge k: RUN cycles k..k+len-1, DONE at k+len, idle and ready afterwards.
    task automatic plan(input int k_in, input logic [2:0] op, input logic [3:0] n,
                        input logic [3:0] data, input logic [15:0] ser);
        int len;
        len = (op == OP_LOAD) ? 1 : ((op >= OP_SHL && op <= OP_WAIT) ? int'(n) : 0);
        for (int j = 0; j < len; j++) begin
            case (op)
                OP_LOAD: begin held.m1 = 1'b1; held.d = data; end
                OP_SHL, OP_SHR: begin
                    held.m1 = 1'b0; held.m0 = 1'b0; held.dir = (op == OP_SHR); held.sin = ser[j];
                end
                OP_ROTL, OP_ROTR: begin
                    held.m1 = 1'b0; held.m0 = 1'b1; held.dir = (op == OP_ROTR);
                end
                default: ;
            endcase
            put(k_in + j, 1'b0, 1'b1, op != OP_WAIT, 1'b0, 1'b0, (op == OP_SHL) || (op == OP_SHR));
        end
        put(k_in + len, 1'b0, 1'b1, 1'b0, 1'b1, op == OP_RSVD, 1'b0);
        for (int i = k_in + len + 1; i < DEPTH; i++) put(i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset(input int from, input int rel);
        held = '0;
        for (int i = from; i <= rel; i++) put(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = rel + 1; i < DEPTH; i++) put(i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] n, input logic [3:0] data,
                         input logic [15:0] ser, input bit hold, output int k_out);
        bit got;
        int c;
        got = 1'b0; c = 0; k_out = -1;
        CMD_OP = op; CMD_CNT = n; CMD_DATA = data; SER_DATA = ser[0]; CMD_VALID = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge CLK);
            if (CMD_READY === 1'b1) begin got = 1'b1; c = cyc; end
        end
        if (!got) begin
            lit("accept_timeout", 0, 1);
            CMD_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        k_out = c + 1;
        plan(k_out, op, n, data, ser);
        #1;
        if (!hold) begin CMD_VALID = 1'b0; CMD_DATA = ~data; CMD_CNT = ~n; end
        if (op == OP_SHL || op == OP_SHR)
            for (int j = 1; j < int'(n); j++) begin
                SER_DATA = ser[j];
                @(posedge CLK);
                #1;
            end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen = 1'b1;
        end
        if (!seen) lit(name, 0, 1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_q[i] = '0;
        held = '0;
        RESET_L = 1'b0; CMD_VALID = 1'b0; CMD_OP = '0; CMD_CNT = '0; CMD_DATA = '0; SER_DATA = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                act = {CMD_READY, BUSY, ENB, DONE, ERR, MODO1, MODO0, DIR, S_IN, SER_REQ, D};
                if (cyc < DEPTH) begin
                    checks++;
                    if (act !== exp_q[cyc]) begin
                        failures++;
                        $display("FAIL cycle_outputs cyc=%0d actual=%b required=%b", cyc, act, exp_q[cyc]);
                    end
                end
                if (ENB === 1'b1) begin
                    if (MODO1) reg_q = D;
                    else if (DIR) reg_q = {MODO0 ? reg_q[0] : S_IN, reg_q[3:1]};
                    else reg_q = {reg_q[2:0], MODO0 ? reg_q[3] : S_IN};
                    hist.push_back(reg_q);
                    enb_total++;
                end
                if (SER_REQ === 1'b1) req_total++;
                if (DONE === 1'b1) begin done_total++; done_cyc = cyc; done_err = ERR; end
            end
        join_none

        // Reset held for three edges.
        repeat (2) @(posedge CLK);
        #1;
        lit("reset_ready", int'(CMD_READY), 0);
        lit("reset_outputs", int'({BUSY, ENB, DONE, ERR, SER_REQ, D}), 0);
        @(posedge CLK);
        #1;
        RESET_L = 1'b1;
        model_reset(0, cyc);
        @(posedge CLK);
        #1;
        lit("ready_after_reset", int'(CMD_READY), 1);

        // LOAD 1011 (count field ignored).
        e0 = enb_total; d0 = done_total;
        issue(OP_LOAD, 4'd9, 4'b1011, 16'h0, 1'b0, k);
        wait_done("load_done_seen");
        lit("load_enb_cycles", enb_total - e0, 1);
        lit("load_done_cyc", done_cyc, k + 1);
        lit("load_done_count", done_total - d0, 1);
        lit("load_reg", int'(reg_q), 4'b1011);

        // SHR N=3, serial 1,0,1: 1011 -> 1101 -> 0110 -> 1011.
        e0 = enb_total; r0 = req_total; h0 = hist.size();
        issue(OP_SHR, 4'd3, 4'b0000, 16'b101, 1'b0, k);
        wait_done("shr_done_seen");
        lit("shr_enb_cycles", enb_total - e0, 3);
        lit("shr_ser_req", req_total - r0, 3);
        lit("shr_done_cyc", done_cyc, k + 3);
        lit("shr_step1", hist_at(h0), 4'b1101);
        lit("shr_step2", hist_at(h0 + 1), 4'b0110);
        lit("shr_step3", hist_at(h0 + 2), 4'b1011);

        // ROTL N=4 brings 1011 back to itself.
        e0 = enb_total; r0 = req_total; h0 = hist.size();
        issue(OP_ROTL, 4'd4, 4'b0000, 16'h0, 1'b0, k);
        wait_done("rotl_done_seen");
        lit("rotl_enb_cycles", enb_total - e0, 4);
        lit("rotl_ser_req", req_total - r0, 0);
        lit("rotl_done_cyc", done_cyc, k + 4);
        lit("rotl_step1", hist_at(h0), 4'b0111);
        lit("rotl_reg", int'(reg_q), 4'b1011);

        // Zero-length commands.
        e0 = enb_total;
        issue(OP_SHL, 4'd0, 4'b0000, 16'h0, 1'b0, k);
        wait_done("shl0_done_seen");
        lit("shl0_done_cyc", done_cyc, k);
        lit("shl0_err", int'(done_err), 0);
        issue(OP_RSVD, 4'd3, 4'b0000, 16'h0, 1'b0, k);
        wait_done("rsvd_done_seen");
        lit("rsvd_done_cyc", done_cyc, k);
        lit("rsvd_err", int'(done_err), 1);
        issue(OP_NOP, 4'd5, 4'b0000, 16'h0, 1'b0, k);
        wait_done("nop_done_seen");
        lit("nop_done_cyc", done_cyc, k);
        lit("zero_len_enb", enb_total - e0, 0);

        // WAIT N=5 with CMD_VALID held into a LOAD 0110: next accept 7 edges later.
        e0 = enb_total;
        issue(OP_WAIT, 4'd5, 4'b0000, 16'h0, 1'b1, k1);
        issue(OP_LOAD, 4'd0, 4'b0110, 16'h0, 1'b0, k2);
        wait_done("wait_load_done_seen");
        lit("wait_accept_gap", k2 - k1, 7);
        lit("wait_load_enb", enb_total - e0, 1);
        lit("wait_load_reg", int'(reg_q), 4'b0110);

        // Full-scale count: SHL N=15, last four bits shifted in are 1,0,0,1.
        e0 = enb_total; r0 = req_total;
        issue(OP_SHL, 4'd15, 4'b0000, 16'h4835, 1'b0, k);
        wait_done("shl15_done_seen");
        lit("shl15_enb_cycles", enb_total - e0, 15);
        lit("shl15_ser_req", req_total - r0, 15);
        lit("shl15_done_cyc", done_cyc, k + 15);
        lit("shl15_reg", int'(reg_q), 4'b1001);

        // Reset during the second RUN cycle of ROTR N=8.
        d0 = done_total;
        issue(OP_ROTR, 4'd8, 4'b0000, 16'h0, 1'b0, k);
        @(posedge CLK);
        #1;
        RESET_L = 1'b0;
        model_reset(cyc, cyc + 2);
        #1;
        lit("abort_enb", int'(ENB), 0);
        lit("abort_busy", int'(BUSY), 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_L = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        lit("abort_no_done", done_total - d0, 0);
        lit("ready_after_abort", int'(CMD_READY), 1);

        issue(OP_LOAD, 4'd0, 4'b0101, 16'h0, 1'b0, k);
        wait_done("post_abort_done_seen");
        lit("post_abort_reg", int'(reg_q), 4'b0101);

        repeat (2) @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
